mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Memory stage of the 5-stage ARM pipeline.
- Sits between the EXE stage register and the MEM/WB stage register.
- Consumes the EXE-register outputs (ALU result as address, store value, memory read/write enables).
- Runs a multi-cycle access to an external single-port synchronous SRAM.
- Asserts freeze to stall the upstream pipeline until the access completes; returns load data for write-back.

Parameters:
- BASE_ADDR, 1024: byte address mapped to SRAM word 0.
- ADDR_W, 16: SRAM word-address width.
- WAIT_CYCLES, 4: SRAM access cycles per transaction. Legal range 1..15; elaboration error outside it.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- mem_r_en  in  1  load request from EXE stage register.
- mem_w_en  in  1  store request from EXE stage register.
- alu_result  in  32  byte address.
- st_val  in  32  store data.
- sram_addr  out  ADDR_W  SRAM word address.
- sram_dq_out  out  32  SRAM write data.
- sram_dq_oe  out  1  drive enable for the SRAM data bus.
- sram_dq_in  in  32  SRAM read data.
- sram_we_n  out  1  SRAM write strobe, active-low.
- mem_rdata  out  32  load result to MEM/WB register.
- ready  out  1  access complete this cycle.
- freeze  out  1  stall for PC, IF/ID, ID/EX and EXE registers.

Behaviour:
- Clocking: one clock domain (clk). rst is asynchronous, active-high.
- Reset values: state=IDLE, sram_addr=0, sram_dq_out=0, sram_dq_oe=0, sram_we_n=1, mem_rdata=0, ready=0, count=0.
- Address map: word = (alu_result - BASE_ADDR) >> 2, truncated to ADDR_W bits, so out-of-window addresses wrap silently. alu_result[1:0] are ignored.
- Request: req = mem_r_en | mem_w_en. If both are set, the write wins and the read is dropped.
- freeze = req & ~ready (combinational). With no request, freeze=0 and the pipeline is never stalled.
- FSM states:
  - IDLE:
    - req=0: stay in IDLE.
    - req=1: at the edge, latch op (write if mem_w_en), word address and st_val into sram_addr / sram_dq_out; set count=WAIT_CYCLES-1; go to ACCESS.
  - ACCESS:
    - Write: sram_we_n=0 and sram_dq_oe=1 throughout the state.
    - Read: sram_we_n=1 and sram_dq_oe=0 throughout the state.
    - count>0: decrement, stay in ACCESS.
    - count=0: go to DONE; on a read, capture sram_dq_in into mem_rdata at this edge.
  - DONE:
    - ready=1, so freeze=0 and the upstream registers advance at this edge.
    - sram_we_n=1, sram_dq_oe=0.
    - Unconditional transition to IDLE, so the same instruction is never re-issued.
- Latency: the request is first seen in cycle 0. ACCESS occupies cycles 1..WAIT_CYCLES. DONE is cycle WAIT_CYCLES+1. freeze is high for exactly WAIT_CYCLES+1 cycles.
- Back-to-back requests: a new request presented in the cycle after DONE is accepted from IDLE normally. This gives one IDLE cycle per access and a throughput of one access per WAIT_CYCLES+2 cycles.
- mem_rdata holds its value until the next read completes; writes do not alter it.
- ready is high only in DONE and is never asserted without a preceding ACCESS.
- Input changes during ACCESS are ignored, since address, data and op are latched. Upstream is frozen, so inputs are stable by construction anyway.
- Reset mid-access: abort immediately to the reset values. No partial write is guaranteed beyond cycles already strobed.

Decomposition:
- Shared package mem_pkg:
  - state enum {IDLE, ACCESS, DONE};
  - constant COUNT_W=4;
  - address-translate function (subtract base, shift, truncate).
- One sub-module, sram_ctrl: holds the FSM, wait counter and SRAM pin drivers.
- mem_stage wraps it and adds address translation, request priority and freeze generation.

Test Plan:
- Reset: assert rst mid-cycle with no clock edge -> all outputs at reset values immediately; freeze=0.
- Store (WAIT_CYCLES=4): mem_w_en=1, alu_result=1032, st_val=0xDEADBEEF -> sram_addr=2 and sram_we_n=0 for 4 cycles; freeze high for 5 cycles; ready=1 in cycle 5.
- Load: mem_r_en=1, alu_result=1032, SRAM model returns 0xDEADBEEF -> mem_rdata=0xDEADBEEF from cycle 5; freeze high for 5 cycles.
- Conflict and wrap:
  - mem_r_en=mem_w_en=1, alu_result=1024+4*65536 -> write issued to sram_addr=0; mem_rdata unchanged.
- Back-to-back: load immediately followed by store -> one IDLE cycle between the DONE and the next ACCESS; each access ready exactly once; total 12 cycles.
- Reset during ACCESS (cycle 2 of a store) -> sram_we_n=1 and state IDLE at once; after release with no request, freeze=0.

Source files
------------

// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_pkg
// Description : Shared types and helpers for the memory stage. Holds the
//               access FSM state encoding, the wait-counter width and the
//               byte-address to SRAM-word-address translation.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_pkg;

    // Wide enough for WAIT_CYCLES-1 with WAIT_CYCLES up to 15.
    localparam int COUNT_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Byte address -> word offset from the window base. The caller truncates
    // the result to its SRAM address width, so out-of-window addresses wrap.
    // The low two byte-lane bits fall out of the shift.
    function automatic logic [31:0] addr_to_word(input logic [31:0] i_byte_addr,
                                                 input logic [31:0] i_base);
        logic [31:0] w_offset;
        w_offset = i_byte_addr - i_base;
        return w_offset >> 2;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_stage_sram_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sram_ctrl
// Description : Access sequencer for a single-port synchronous SRAM. Latches
//               one request from IDLE, holds the SRAM pins for WAIT_CYCLES
//               cycles in ACCESS, then spends one cycle in DONE signalling
//               completion before returning to IDLE.
// Ports       : clk, rst          - clock, async active-high reset
//               i_req, i_we       - request strobe and write-select
//               i_word_addr       - translated SRAM word address
//               i_wdata           - store data
//               i_sram_dq_in      - SRAM read data
//               o_sram_addr       - latched SRAM word address
//               o_sram_dq_out     - latched SRAM write data
//               o_sram_dq_oe      - data-bus drive enable (writes only)
//               o_sram_we_n       - active-low write strobe
//               o_rdata           - last completed load result
//               o_ready           - high in the DONE cycle
// Revision    : 1.0 - initial release
// ============================================================================
module sram_ctrl
    import mem_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int WAIT_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_word_addr,
    input  logic [31:0]       i_wdata,
    input  logic [31:0]       i_sram_dq_in,
    output logic [ADDR_W-1:0] o_sram_addr,
    output logic [31:0]       o_sram_dq_out,
    output logic              o_sram_dq_oe,
    output logic              o_sram_we_n,
    output logic [31:0]       o_rdata,
    output logic              o_ready
);

    if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_bad_wait_cycles
        $error("sram_ctrl: WAIT_CYCLES must lie in 1..15");
    end

    localparam logic [COUNT_W-1:0] c_count_init = COUNT_W'(WAIT_CYCLES - 1);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [COUNT_W-1:0]   r_count;
    logic [COUNT_W-1:0]   w_count_nxt;
    logic                 r_we;
    logic [ADDR_W-1:0]    r_addr;
    logic [31:0]          r_wdata;
    logic [31:0]          r_rdata;
    logic                 w_accept;
    logic                 w_last_access;

    assign w_accept      = (r_state == IDLE) && i_req;
    assign w_last_access = (r_state == ACCESS) && (r_count == '0);

    // State and wait counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        case (r_state)
            IDLE: begin
                if (i_req) begin
                    w_state_nxt = ACCESS;
                    w_count_nxt = c_count_init;
                end
            end
            ACCESS: begin
                if (r_count == '0) begin
                    w_state_nxt = DONE;
                end else begin
                    w_count_nxt = r_count - 1'b1;
                end
            end
            DONE: begin
                // Always drop back to IDLE so the upstream instruction that
                // just advanced is never issued a second time.
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Transaction latches: op, address and data are frozen for the whole
    // access regardless of what the inputs do afterwards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            if (w_accept) begin
                r_we    <= i_we;
                r_addr  <= i_word_addr;
                r_wdata <= i_wdata;
            end
            if (w_last_access && !r_we) begin
                r_rdata <= i_sram_dq_in;
            end
        end
    end

    // Pin drivers decode straight from registered state, so an async reset
    // releases the write strobe without waiting for a clock edge.
    assign o_sram_dq_oe  = (r_state == ACCESS) && r_we;
    assign o_sram_we_n   = !((r_state == ACCESS) && r_we);
    assign o_sram_addr   = r_addr;
    assign o_sram_dq_out = r_wdata;
    assign o_rdata       = r_rdata;
    assign o_ready       = (r_state == DONE);

endmodule
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage
// Description : MEM stage of the 5-stage ARM pipeline. Translates the ALU
//               result into an SRAM word address, merges load/store requests
//               (store wins), runs the SRAM access through sram_ctrl and
//               freezes the upstream pipeline until the access completes.
// Ports       : clk, rst              - clock, async active-high reset
//               mem_r_en, mem_w_en    - load / store request from EXE reg
//               alu_result            - byte address
//               st_val                - store data
//               sram_addr             - SRAM word address
//               sram_dq_out           - SRAM write data
//               sram_dq_oe            - SRAM data-bus drive enable
//               sram_dq_in            - SRAM read data
//               sram_we_n             - SRAM write strobe, active-low
//               mem_rdata             - load result to MEM/WB register
//               ready                 - access complete this cycle
//               freeze                - upstream stall
// Revision    : 1.0 - initial release
// ============================================================================
module mem_stage
    import mem_pkg::*;
#(
    parameter int unsigned BASE_ADDR   = 1024,
    parameter int          ADDR_W      = 16,
    parameter int          WAIT_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_r_en,
    input  logic              mem_w_en,
    input  logic [31:0]       alu_result,
    input  logic [31:0]       st_val,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [31:0]       sram_dq_out,
    output logic              sram_dq_oe,
    input  logic [31:0]       sram_dq_in,
    output logic              sram_we_n,
    output logic [31:0]       mem_rdata,
    output logic              ready,
    output logic              freeze
);

    localparam logic [31:0] c_base = 32'(BASE_ADDR);

    logic              w_req;
    logic [ADDR_W-1:0] w_word_addr;

    // A simultaneous read is simply dropped: mem_w_en alone selects the op.
    assign w_req       = mem_r_en | mem_w_en;
    assign w_word_addr = ADDR_W'(addr_to_word(alu_result, c_base));

    // Stall until the DONE cycle, which lets the upstream registers advance.
    assign freeze = w_req & ~ready;

    sram_ctrl #(
        .ADDR_W      (ADDR_W),
        .WAIT_CYCLES (WAIT_CYCLES)
    ) u_ctrl (
        .clk           (clk),
        .rst           (rst),
        .i_req         (w_req),
        .i_we          (mem_w_en),
        .i_word_addr   (w_word_addr),
        .i_wdata       (st_val),
        .i_sram_dq_in  (sram_dq_in),
        .o_sram_addr   (sram_addr),
        .o_sram_dq_out (sram_dq_out),
        .o_sram_dq_oe  (sram_dq_oe),
        .o_sram_we_n   (sram_we_n),
        .o_rdata       (mem_rdata),
        .o_ready       (ready)
    );

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_stage
// Description : Directed bench for mem_stage with WAIT_CYCLES=4 and a
//               registered-read synchronous SRAM model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_stage;
    import mem_pkg::*;

    logic        clk;
    logic        rst;
    logic        mem_r_en;
    logic        mem_w_en;
    logic [31:0] alu_result;
    logic [31:0] st_val;
    logic [15:0] sram_addr;
    logic [31:0] sram_dq_out;
    logic        sram_dq_oe;
    logic [31:0] sram_dq_in;
    logic        sram_we_n;
    logic [31:0] mem_rdata;
    logic        ready;
    logic        freeze;

    int passed;
    int total;

    logic [31:0] sram_mem [0:255];

    mem_stage #(
        .BASE_ADDR   (1024),
        .ADDR_W      (16),
        .WAIT_CYCLES (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .mem_r_en    (mem_r_en),
        .mem_w_en    (mem_w_en),
        .alu_result  (alu_result),
        .st_val      (st_val),
        .sram_addr   (sram_addr),
        .sram_dq_out (sram_dq_out),
        .sram_dq_oe  (sram_dq_oe),
        .sram_dq_in  (sram_dq_in),
        .sram_we_n   (sram_we_n),
        .mem_rdata   (mem_rdata),
        .ready       (ready),
        .freeze      (freeze)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Synchronous SRAM: write on strobe, registered read of the addressed word.
    always @(posedge clk) begin
        if (!sram_we_n && sram_dq_oe) begin
            sram_mem[sram_addr[7:0]] <= sram_dq_out;
        end
        sram_dq_in <= sram_mem[sram_addr[7:0]];
    end

    task automatic test_reset();
        rst = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        // Still before the first rising edge: reset must act asynchronously.
        total++;
        if ({sram_addr, sram_dq_out, sram_dq_oe, sram_we_n, mem_rdata, ready, freeze}
            !== {16'h0, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0}) begin
            $display("FAIL reset_async addr=%h dq=%h oe=%b we_n=%b rdata=%h ready=%b freeze=%b exp 0/0/0/1/0/0/0",
                     sram_addr, sram_dq_out, sram_dq_oe, sram_we_n, mem_rdata, ready, freeze);
        end else passed++;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        total++;
        if ({ready, freeze, sram_we_n} !== 3'b001) begin
            $display("FAIL reset_release ready/freeze/we_n=%b exp 001", {ready, freeze, sram_we_n});
        end else passed++;
    endtask

    task automatic test_store();
        logic [5:0] f_pat, r_pat, we_pat, oe_pat;
        f_pat  = 6'b011111;
        r_pat  = 6'b100000;
        we_pat = 6'b100001;
        oe_pat = 6'b011110;
        @(posedge clk);
        #1;
        mem_w_en = 1'b1; alu_result = 32'd1032; st_val = 32'hDEADBEEF;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            total++;
            if ({freeze, ready, sram_we_n, sram_dq_oe} !== {f_pat[c], r_pat[c], we_pat[c], oe_pat[c]}) begin
                $display("FAIL store_ctl c%0d freeze/ready/we_n/oe=%b exp %b", c,
                         {freeze, ready, sram_we_n, sram_dq_oe}, {f_pat[c], r_pat[c], we_pat[c], oe_pat[c]});
            end else passed++;
            if (c >= 1 && c <= 4) begin
                total++;
                if (sram_addr !== 16'd2 || sram_dq_out !== 32'hDEADBEEF) begin
                    $display("FAIL store_bus c%0d addr=%0d dq=%h exp 2 DEADBEEF", c, sram_addr, sram_dq_out);
                end else passed++;
            end
            @(posedge clk);
            #1;
            if (c == 5) mem_w_en = 1'b0;
        end
        @(negedge clk);
        total++;
        if ({freeze, ready} !== 2'b00 || sram_mem[2] !== 32'hDEADBEEF || mem_rdata !== 32'h0) begin
            $display("FAIL store_after freeze/ready=%b mem2=%h rdata=%h exp 00 DEADBEEF 0",
                     {freeze, ready}, sram_mem[2], mem_rdata);
        end else passed++;
    endtask

    task automatic test_load();
        logic [5:0] f_pat, r_pat;
        f_pat = 6'b011111;
        r_pat = 6'b100000;
        @(posedge clk);
        #1;
        mem_r_en = 1'b1; alu_result = 32'd1032; st_val = 32'h0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            total++;
            if ({freeze, ready, sram_we_n, sram_dq_oe} !== {f_pat[c], r_pat[c], 1'b1, 1'b0}) begin
                $display("FAIL load_ctl c%0d freeze/ready/we_n/oe=%b exp %b", c,
                         {freeze, ready, sram_we_n, sram_dq_oe}, {f_pat[c], r_pat[c], 1'b1, 1'b0});
            end else passed++;
            if (c == 4) begin
                total++;
                if (mem_rdata !== 32'h0) begin
                    $display("FAIL load_early c4 rdata=%h exp 00000000", mem_rdata);
                end else passed++;
            end
            if (c == 5) begin
                total++;
                if (mem_rdata !== 32'hDEADBEEF) begin
                    $display("FAIL load_data c5 rdata=%h exp DEADBEEF", mem_rdata);
                end else passed++;
            end
            @(posedge clk);
            #1;
            if (c == 5) mem_r_en = 1'b0;
        end
        @(negedge clk);
        total++;
        if (mem_rdata !== 32'hDEADBEEF || freeze !== 1'b0) begin
            $display("FAIL load_hold rdata=%h freeze=%b exp DEADBEEF 0", mem_rdata, freeze);
        end else passed++;
    endtask

    task automatic test_conflict_wrap();
        @(posedge clk);
        #1;
        mem_r_en = 1'b1; mem_w_en = 1'b1;
        alu_result = 32'd1024 + 32'd262144; st_val = 32'h12345678;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (c == 1) begin
                total++;
                if (sram_addr !== 16'd0 || sram_we_n !== 1'b0 || sram_dq_oe !== 1'b1) begin
                    $display("FAIL conflict_bus addr=%0d we_n=%b oe=%b exp 0 0 1", sram_addr, sram_we_n, sram_dq_oe);
                end else passed++;
            end
            if (c == 5) begin
                total++;
                if (ready !== 1'b1 || mem_rdata !== 32'hDEADBEEF) begin
                    $display("FAIL conflict_done ready=%b rdata=%h exp 1 DEADBEEF", ready, mem_rdata);
                end else passed++;
            end
            @(posedge clk);
            #1;
            if (c == 5) begin
                mem_r_en = 1'b0; mem_w_en = 1'b0;
            end
        end
        @(negedge clk);
        total++;
        if (sram_mem[0] !== 32'h12345678 || mem_rdata !== 32'hDEADBEEF) begin
            $display("FAIL conflict_effect mem0=%h rdata=%h exp 12345678 DEADBEEF", sram_mem[0], mem_rdata);
        end else passed++;
    endtask

    task automatic test_back_to_back();
        logic [11:0] r_pat, we_pat;
        int          n_ready;
        r_pat   = 12'b1000_0010_0000;
        we_pat  = 12'b1000_0111_1111;
        n_ready = 0;
        @(posedge clk);
        #1;
        mem_r_en = 1'b1; alu_result = 32'd1036; st_val = 32'h0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (ready === 1'b1) n_ready++;
            total++;
            if ({freeze, ready, sram_we_n} !== {~r_pat[c], r_pat[c], we_pat[c]}) begin
                $display("FAIL b2b_ctl c%0d freeze/ready/we_n=%b exp %b", c,
                         {freeze, ready, sram_we_n}, {~r_pat[c], r_pat[c], we_pat[c]});
            end else passed++;
            if (c == 5 || c == 11) begin
                total++;
                if (mem_rdata !== 32'hCAFEF00D) begin
                    $display("FAIL b2b_rdata c%0d rdata=%h exp CAFEF00D", c, mem_rdata);
                end else passed++;
            end
            @(posedge clk);
            #1;
            if (c == 5) begin
                mem_r_en = 1'b0; mem_w_en = 1'b1; alu_result = 32'd1040; st_val = 32'hA5A5A5A5;
            end
            if (c == 11) mem_w_en = 1'b0;
        end
        @(negedge clk);
        total++;
        if (n_ready != 2 || sram_mem[4] !== 32'hA5A5A5A5 || freeze !== 1'b0) begin
            $display("FAIL b2b_summary readies=%0d mem4=%h freeze=%b exp 2 A5A5A5A5 0", n_ready, sram_mem[4], freeze);
        end else passed++;
    endtask

    task automatic test_reset_mid_access();
        @(posedge clk);
        #1;
        mem_w_en = 1'b1; alu_result = 32'd1044; st_val = 32'h55AA55AA;
        @(posedge clk);
        #1;
        @(posedge clk);
        #3;
        // Cycle 2 of the store, write strobe active.
        total++;
        if (sram_we_n !== 1'b0) begin
            $display("FAIL rstmid_pre we_n=%b exp 0", sram_we_n);
        end else passed++;
        rst = 1'b1;
        #1;
        total++;
        if ({sram_we_n, sram_dq_oe, ready} !== 3'b100 || sram_addr !== 16'd0 || sram_dq_out !== 32'h0 ||
            mem_rdata !== 32'h0 || dut.u_ctrl.r_state !== IDLE) begin
            $display("FAIL rstmid_abort we_n/oe/ready=%b addr=%h dq=%h rdata=%h state=%0d exp 100 0 0 0 0",
                     {sram_we_n, sram_dq_oe, ready}, sram_addr, sram_dq_out, mem_rdata, dut.u_ctrl.r_state);
        end else passed++;
        mem_w_en = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            total++;
            if ({freeze, ready, sram_we_n} !== 3'b001) begin
                $display("FAIL rstmid_idle c%0d freeze/ready/we_n=%b exp 001", c, {freeze, ready, sram_we_n});
            end else passed++;
        end
    endtask

    initial begin
        passed     = 0;
        total      = 0;
        rst        = 1'b0;
        mem_r_en   = 1'b0;
        mem_w_en   = 1'b0;
        alu_result = 32'h0;
        st_val     = 32'h0;
        sram_dq_in = 32'h0;
        for (int i = 0; i < 256; i++) sram_mem[i] = 32'h0;
        sram_mem[3] = 32'hCAFEF00D;

        test_reset();
        test_store();
        test_load();
        test_conflict_wrap();
        test_back_to_back();
        test_reset_mid_access();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
